// File: rtl/register_unloader_pkg.sv
// rtl/register_unloader_pkg.sv - shared state type and sizing helpers for register loader/unloader blocks
package register_unloader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unload_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Counter width; never below one bit so single-beat configurations still elaborate.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/register_unloader.sv
// rtl/register_unloader.sv - wide parallel value unloaded LSB-first as WORD-bit beats over valid/ready
module register_unloader
  import register_unloader_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] din,
  output logic [WORD-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            busy
);

  localparam int NUM_WORDS = ceil_div(SIZE, WORD);
  localparam int CNT_W     = clog2_min1(NUM_WORDS);
  localparam int PAD_W     = NUM_WORDS * WORD;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  unload_state_e    state_q, state_d;
  logic [PAD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAD_W-1:0] din_ext;
  logic             beat_fire;
  logic             last_beat;
  logic             load_fire;

  always_comb begin
    din_ext            = '0;
    din_ext[SIZE-1:0]  = din;
  end

  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign dout       = shreg_q[WORD-1:0];
  assign last_beat  = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign dout_last  = last_beat;
  assign beat_fire  = dout_valid && dout_ready;
  // A new value may be taken on the very handshake that retires the last beat.
  assign load_ready = (state_q == IDLE) || (beat_fire && last_beat);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_fire) begin
      shreg_d = din_ext;
      cnt_d   = '0;
      state_d = SEND;
    end else if (beat_fire) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        shreg_d = shreg_q >> WORD;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_register_unloader.sv
// tb/tb_register_unloader.sv - scoreboard bench for register_unloader (32/8, 20/8 and 8/8 configurations)
module tb_register_unloader;

  logic clk;
  logic resetn;

  logic        lv, lr, dv, dr, dl, busy;
  logic [31:0] din;
  logic [7:0]  dout;

  logic        lv_p, lr_p, dv_p, dr_p, dl_p, busy_p;
  logic [19:0] din_p;
  logic [7:0]  dout_p;

  logic        lv_s, lr_s, dv_s, dr_s, dl_s, busy_s;
  logic [7:0]  din_s;
  logic [7:0]  dout_s;

  int checks;
  int errors;
  logic rand_rdy;

  logic [8:0] q_main[$];
  logic [8:0] q_pad[$];
  logic [8:0] q_one[$];

  register_unloader #(.SIZE(32), .WORD(8)) dut (
    .clk(clk), .resetn(resetn), .load_valid(lv), .load_ready(lr), .din(din),
    .dout(dout), .dout_valid(dv), .dout_ready(dr), .dout_last(dl), .busy(busy)
  );

  register_unloader #(.SIZE(20), .WORD(8)) dut_pad (
    .clk(clk), .resetn(resetn), .load_valid(lv_p), .load_ready(lr_p), .din(din_p),
    .dout(dout_p), .dout_valid(dv_p), .dout_ready(dr_p), .dout_last(dl_p), .busy(busy_p)
  );

  register_unloader #(.SIZE(8), .WORD(8)) dut_one (
    .clk(clk), .resetn(resetn), .load_valid(lv_s), .load_ready(lr_s), .din(din_s),
    .dout(dout_s), .dout_valid(dv_s), .dout_ready(dr_s), .dout_last(dl_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: beat k of a value is its k-th byte counted from the LSB, zero above the value.
  function automatic logic [8:0] ref_beat(input logic [63:0] v, input int k, input int nw);
    logic [63:0] s;
    s = v >> (k * 8);
    return {(k == nw - 1), s[7:0]};
  endfunction

  task automatic push_value(input logic [63:0] v, input int nw, input int which);
    for (int k = 0; k < nw; k++) begin
      if (which == 0) q_main.push_back(ref_beat(v, k, nw));
      else if (which == 1) q_pad.push_back(ref_beat(v, k, nw));
      else q_one.push_back(ref_beat(v, k, nw));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, load_valid still high.
  task automatic drive_load(input logic [31:0] v, output int waits);
    din = v;
    lv = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!lr && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    check("load_accept_timeout", {63'd0, lr}, 64'd1);
    if (lr) push_value({32'd0, v}, 4, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || q_main.size() != 0) && n < 400) begin
      n++;
      @(negedge clk);
    end
    check(name, {63'd0, (busy || q_main.size() != 0)}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic       hold_pending;
  logic [8:0] held;

  always @(negedge clk) begin
    if (resetn) begin
      check("busy_eq_valid", {63'd0, busy}, {63'd0, dv});
      if (hold_pending && dv) check("backpressure_hold", {55'd0, dl, dout}, {55'd0, held});
      hold_pending = dv && !dr;
      held = {dl, dout};
      if (dv && dr) begin
        if (q_main.size() == 0) begin
          check("unexpected_beat", {55'd0, dl, dout}, 64'h1ff);
        end else begin
          check("beat_main", {55'd0, dl, dout}, {55'd0, q_main.pop_front()});
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (resetn && dv_p && dr_p) begin
      if (q_pad.size() == 0) check("unexpected_beat_pad", {55'd0, dl_p, dout_p}, 64'h1ff);
      else check("beat_pad", {55'd0, dl_p, dout_p}, {55'd0, q_pad.pop_front()});
    end
    if (resetn && dv_s && dr_s) begin
      if (q_one.size() == 0) check("unexpected_beat_one", {55'd0, dl_s, dout_s}, 64'h1ff);
      else check("beat_one", {55'd0, dl_s, dout_s}, {55'd0, q_one.pop_front()});
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      dr = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    checks = 0;
    errors = 0;
    rand_rdy = 1'b0;
    hold_pending = 1'b0;
    held = '0;
    resetn = 1'b0;
    lv = 0; din = 0; dr = 0;
    lv_p = 0; din_p = 0; dr_p = 0;
    lv_s = 0; din_s = 0; dr_s = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("reset_valid", {63'd0, dv}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_dout", {56'd0, dout}, 64'd0);
    check("reset_last", {63'd0, dl}, 64'd0);
    check("reset_load_ready", {61'd0, lr, lr_p, lr_s}, 64'd7);
    @(posedge clk);
    #1;

    // Basic unload
    dr = 1'b1;
    drive_load(32'hA1B2C3D4, w);
    check("basic_accept_wait", 64'(w), 64'd0);
    lv = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("basic_busy_falls", {62'd0, busy, dv}, 64'd0);
    check("basic_drained", 64'(q_main.size()), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure while C3 is shown
    drive_load(32'hA1B2C3D4, w);
    lv = 1'b0;
    @(posedge clk);
    #1;
    dr = 1'b0;
    @(negedge clk);
    check("bp_c3", {54'd0, dv, dl, dout}, {54'd0, 2'b10, 8'hC3});
    @(posedge clk);
    @(posedge clk);
    #1;
    check("bp_c3_still", {54'd0, dv, dl, dout}, {54'd0, 2'b10, 8'hC3});
    dr = 1'b1;
    wait_idle("bp_drain");

    // Back-to-back: second value accepted only on the A1 handshake, no bubble
    drive_load(32'hA1B2C3D4, w);
    drive_load(32'h11223344, w);
    check("b2b_wait_cycles", 64'(w), 64'd3);
    lv = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", {55'd0, dv, dout}, {55'd0, 1'b1, 8'h44});
    wait_idle("b2b_drain");

    // Asynchronous reset while C3 is shown
    drive_load(32'hA1B2C3D4, w);
    lv = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_outputs", {53'd0, dv, busy, dl, dout}, 64'd0);
    q_main.delete();
    @(posedge clk);
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("areset_load_ready", {63'd0, lr}, 64'd1);
    drive_load(32'h0BADF00D, w);
    lv = 1'b0;
    wait_idle("areset_fresh_drain");

    // Padding: SIZE=20 gives beats DE, BC, 0A
    dr_p = 1'b1;
    din_p = 20'hABCDE;
    lv_p = 1'b1;
    @(negedge clk);
    check("pad_accept", {63'd0, lr_p}, 64'd1);
    push_value(64'hABCDE, 3, 1);
    @(posedge clk);
    #1;
    lv_p = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pad_done", {62'd0, busy_p, 1'(q_pad.size() != 0)}, 64'd0);
    @(posedge clk);
    #1;

    // Single-beat: consecutive loads stream on consecutive cycles
    dr_s = 1'b1;
    din_s = 8'h5A;
    lv_s = 1'b1;
    @(negedge clk);
    check("one_accept_a", {63'd0, lr_s}, 64'd1);
    push_value(64'h5A, 1, 2);
    @(posedge clk);
    #1;
    din_s = 8'h3C;
    @(negedge clk);
    check("one_accept_b", {63'd0, lr_s}, 64'd1);
    push_value(64'h3C, 1, 2);
    @(posedge clk);
    #1;
    lv_s = 1'b0;
    @(negedge clk);
    check("one_second_beat", {54'd0, dv_s, dl_s, dout_s}, {54'd0, 2'b11, 8'h3C});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("one_done", {62'd0, busy_s, 1'(q_one.size() != 0)}, 64'd0);
    @(posedge clk);
    #1;

    // Randomized loads and backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      lv = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_load($urandom, w);
    end
    lv = 1'b0;
    wait_idle("random_drain");
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
